tri_nxw_way_array_1r1w: RTL and testbench

Parametrised N-way, 1-read/1-write synchronous array for cache directories, tag arrays and LRU/valid stores. It generalises the fixed 128-entry, 34-bit, 4-way array to any depth, width and way count. Over that fixed array it adds:
- a reset-time and on-demand clear sequencer;
- same-cycle write-first bypass, plus one-stage late-write forwarding;
- per-way even-parity generation and checking, with an error-inject hook.

It sits directly behind the directory/tag pipeline and returns registered read data two cycles after the read request.

---
 rtl/tri_nxw_way_array_1r1w.sv | 175 +++++++++++++++++
 tb/tb_tri_nxw_way_array_1r1w.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tri_nxw_way_array_1r1w.sv
// N-way, 1-read/1-write synchronous array with a clear sequencer, write-first bypass,
// one-stage late-write forwarding and per-way even parity with an error-inject hook.
module tri_nxw_way_array_1r1w #(
   parameter int               ADDR_WIDTH = 7,
   parameter int               WIDTH      = 34,
   parameter int               WAYS       = 4,
   parameter logic [WIDTH-1:0] INIT_VAL   = '0
) (
   input  logic                  nclk,
   input  logic                  rst,
   input  logic                  init_req,
   output logic                  init_busy,
   input  logic                  rd_act,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [WAYS-1:0]       wr_way,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [WIDTH*WAYS-1:0] data_in,
   input  logic [WAYS-1:0]       par_inj,
   output logic [WIDTH*WAYS-1:0] data_out,
   output logic                  rd_val,
   output logic [WAYS-1:0]       par_err
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   // Stored word layout: {parity, data}; XOR over the whole word is the parity check.
   typedef logic [WIDTH:0] word_t;

   typedef enum logic {ST_IDLE, ST_INIT} state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;

   word_t [WAYS-1:0]      mem_q [DEPTH];

   logic [WAYS-1:0]       mem_we;
   logic [ADDR_WIDTH-1:0] mem_waddr;
   word_t [WAYS-1:0]      mem_wword;

   logic                  rd_accept;
   word_t [WAYS-1:0]      rd_word;
   word_t [WAYS-1:0]      s1_word_q, s1_word_d;
   logic [ADDR_WIDTH-1:0] s1_addr_q, s1_addr_d;
   logic                  s1_val_q, s1_val_d;

   word_t [WAYS-1:0]      fwd_word;
   logic [WIDTH*WAYS-1:0] data_out_q, data_out_d;
   logic [WAYS-1:0]       par_err_q, par_err_d;
   logic                  rd_val_q, rd_val_d;

   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      case (state_q)
         ST_IDLE: begin
            if (init_req) begin
               state_d    = ST_INIT;
               clr_addr_d = '0;
            end
         end
         ST_INIT: begin
            clr_addr_d = clr_addr_q + 1'b1;
            if (clr_addr_q == '1) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_INIT;
      endcase
   end

   always_ff @(posedge nclk) begin
      if (rst) begin
         state_q    <= ST_INIT;
         clr_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
      end
   end

   assign init_busy = (state_q == ST_INIT);

   // Single write port shared by the clear sequencer and user writes.
   always_comb begin
      mem_we    = '0;
      mem_waddr = wr_addr;
      mem_wword = '0;
      for (int w = 0; w < WAYS; w++) begin
         mem_wword[w] = {(^data_in[w*WIDTH +: WIDTH]) ^ par_inj[w], data_in[w*WIDTH +: WIDTH]};
      end
      if (!rst) begin
         if (init_busy) begin
            mem_we    = '1;
            mem_waddr = clr_addr_q;
            for (int w = 0; w < WAYS; w++) begin
               mem_wword[w] = {^INIT_VAL, INIT_VAL};
            end
         end else begin
            mem_we = wr_way;
         end
      end
   end

   always_ff @(posedge nclk) begin
      for (int w = 0; w < WAYS; w++) begin
         if (mem_we[w]) begin
            mem_q[mem_waddr][w] <= mem_wword[w];
         end
      end
   end

   assign rd_accept = rd_act & ~init_busy;

   // Stage 1: array read with write-first bypass per way.
   always_comb begin
      rd_word = mem_q[rd_addr];
      for (int w = 0; w < WAYS; w++) begin
         if (mem_we[w] && (mem_waddr == rd_addr)) begin
            rd_word[w] = mem_wword[w];
         end
      end
      s1_val_d  = rd_accept;
      s1_addr_d = rd_accept ? rd_addr : s1_addr_q;
      s1_word_d = rd_accept ? rd_word : s1_word_q;
   end

   always_ff @(posedge nclk) begin
      if (rst) begin
         s1_val_q  <= 1'b0;
         s1_addr_q <= '0;
         s1_word_q <= '0;
      end else begin
         s1_val_q  <= s1_val_d;
         s1_addr_q <= s1_addr_d;
         s1_word_q <= s1_word_d;
      end
   end

   // Stage 2: a write landing on the held address overrides s1 before capture.
   always_comb begin
      fwd_word   = s1_word_q;
      data_out_d = data_out_q;
      par_err_d  = par_err_q;
      rd_val_d   = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
         if (mem_we[w] && (mem_waddr == s1_addr_q)) begin
            fwd_word[w] = mem_wword[w];
         end
      end
      if (s1_val_q) begin
         rd_val_d = 1'b1;
         for (int w = 0; w < WAYS; w++) begin
            data_out_d[w*WIDTH +: WIDTH] = fwd_word[w][WIDTH-1:0];
            par_err_d[w]                 = ^fwd_word[w];
         end
      end
   end

   always_ff @(posedge nclk) begin
      if (rst) begin
         data_out_q <= '0;
         par_err_q  <= '0;
         rd_val_q   <= 1'b0;
      end else begin
         data_out_q <= data_out_d;
         par_err_q  <= par_err_d;
         rd_val_q   <= rd_val_d;
      end
   end

   assign data_out = data_out_q;
   assign par_err  = par_err_q;
   assign rd_val   = rd_val_q;

endmodule

// File: tb/tb_tri_nxw_way_array_1r1w.sv
// Randomized and directed bench for tri_nxw_way_array_1r1w against a memory-snapshot
// model: a read issued at t returns the array as it stands after all writes through t+1.
module tb_tri_nxw_way_array_1r1w;

   localparam int AW    = 7;
   localparam int W     = 34;
   localparam int NW    = 4;
   localparam int DW    = W * NW;
   localparam int DEPTH = 1 << AW;
   localparam logic [W-1:0] IV = 34'h2_5A5A_0F0F;

   logic          nclk = 1'b0;
   logic          rst;
   logic          init_req;
   logic          init_busy;
   logic          rd_act;
   logic [AW-1:0] rd_addr;
   logic [NW-1:0] wr_way;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] data_in;
   logic [NW-1:0] par_inj;
   logic [DW-1:0] data_out;
   logic          rd_val;
   logic [NW-1:0] par_err;

   tri_nxw_way_array_1r1w #(
      .ADDR_WIDTH(AW),
      .WIDTH     (W),
      .WAYS      (NW),
      .INIT_VAL  (IV)
   ) dut (
      .nclk     (nclk),
      .rst      (rst),
      .init_req (init_req),
      .init_busy(init_busy),
      .rd_act   (rd_act),
      .rd_addr  (rd_addr),
      .wr_way   (wr_way),
      .wr_addr  (wr_addr),
      .data_in  (data_in),
      .par_inj  (par_inj),
      .data_out (data_out),
      .rd_val   (rd_val),
      .par_err  (par_err)
   );

   always #5 nclk = ~nclk;

   // Reference model: stored {parity, data} per entry and way.
   logic [W:0]    ref_mem [DEPTH][NW];
   int            busy_left;
   int            clr_ptr;
   bit            pend_v;
   logic [AW-1:0] pend_a;
   logic [DW-1:0] exp_dout;
   logic [NW-1:0] exp_perr;
   bit            exp_val;
   int            n_chk;
   int            n_fail;
   int            cnt;

   task automatic checkVal(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic modelStep();
      bit accept;
      accept = !rst && rd_act && (busy_left == 0);
      if (rst) begin
         busy_left = DEPTH;
         clr_ptr   = 0;
         pend_v    = 1'b0;
         exp_dout  = '0;
         exp_perr  = '0;
         exp_val   = 1'b0;
      end else begin
         if (busy_left > 0) begin
            for (int w = 0; w < NW; w++) ref_mem[clr_ptr][w] = {^IV, IV};
            clr_ptr++;
            busy_left--;
         end else begin
            for (int w = 0; w < NW; w++) begin
               if (wr_way[w])
                  ref_mem[wr_addr][w] = {(^data_in[w*W +: W]) ^ par_inj[w], data_in[w*W +: W]};
            end
            if (init_req) begin
               busy_left = DEPTH;
               clr_ptr   = 0;
            end
         end
         exp_val = pend_v;
         if (pend_v) begin
            for (int w = 0; w < NW; w++) begin
               exp_dout[w*W +: W] = ref_mem[pend_a][w][W-1:0];
               exp_perr[w]        = ^ref_mem[pend_a][w];
            end
         end
         pend_v = accept;
         pend_a = rd_addr;
      end
   endtask

   task automatic checkOutput(input string tag);
      checkVal({tag, ":init_busy"}, DW'(init_busy), DW'(busy_left > 0));
      checkVal({tag, ":rd_val"}, DW'(rd_val), DW'(exp_val));
      checkVal({tag, ":data_out"}, data_out, exp_dout);
      checkVal({tag, ":par_err"}, DW'(par_err), DW'(exp_perr));
   endtask

   task automatic applyStimulus(input bit r, input bit ir, input bit ra, input logic [AW-1:0] raddr,
                                input logic [NW-1:0] ww, input logic [AW-1:0] waddr,
                                input logic [DW-1:0] din, input logic [NW-1:0] pinj, input string tag);
      rst      = r;
      init_req = ir;
      rd_act   = ra;
      rd_addr  = raddr;
      wr_way   = ww;
      wr_addr  = waddr;
      data_in  = din;
      par_inj  = pinj;
      modelStep();
      @(posedge nclk);
      #1;
      checkOutput(tag);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, '0, '0, '0, '0, '0, "idle");
   endtask

   task automatic readAt(input logic [AW-1:0] a, input string tag);
      applyStimulus(0, 0, 1, a, '0, '0, '0, '0, tag);
   endtask

   function automatic logic [DW-1:0] wayData(input int way, input logic [W-1:0] v);
      logic [DW-1:0] d;
      d = '0;
      d[way*W +: W] = v;
      return d;
   endfunction

   task automatic randStep(input int amax, input string tag);
      logic [DW-1:0] d;
      logic [NW-1:0] ww;
      logic [NW-1:0] pi;
      d = '0;
      for (int w = 0; w < NW; w++) d[w*W +: W] = W'({$urandom(), $urandom()});
      ww = ($urandom_range(0, 3) == 0) ? '0 : NW'($urandom());
      pi = ($urandom_range(0, 7) == 0) ? NW'($urandom()) : '0;
      applyStimulus(0, 0, 1'($urandom()), AW'($urandom_range(0, amax)), ww,
                    AW'($urandom_range(0, amax)), d, pi, tag);
   endtask

   task automatic countBusy(input int start, output int c);
      c = start;
      for (int i = 0; i < DEPTH + 8; i++) begin
         if (!init_busy) break;
         randStep(DEPTH - 1, "busy");
         if (init_busy) c++;
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      n_chk = 0; n_fail = 0; busy_left = 0; clr_ptr = 0;
      pend_v = 1'b0; pend_a = '0; exp_dout = '0; exp_perr = '0; exp_val = 1'b0;

      $display("[TB] reset and power-on clear");
      applyStimulus(1, 0, 0, '0, '0, '0, '0, '0, "reset");
      applyStimulus(1, 0, 1, 7'd3, '0, '0, '0, '0, "reset");
      checkVal("reset_busy", DW'(init_busy), DW'(1'b1));
      checkVal("reset_rd_val", DW'(rd_val), DW'(1'b0));
      checkVal("reset_dout", data_out, '0);
      countBusy(init_busy ? 1 : 0, cnt);
      checkVal("busy_len_reset", DW'(cnt), DW'(DEPTH));

      $display("[TB] read back cleared array");
      for (int a = 0; a < DEPTH; a++) begin
         readAt(AW'(a), "init_rd");
         if (a > 0) begin
            checkVal("init_rd_val", DW'(rd_val), DW'(1'b1));
            checkVal("init_rd_way3", DW'(data_out[3*W +: W]), DW'(IV));
         end
      end
      idle(2);

      $display("[TB] basic write/read");
      applyStimulus(0, 0, 0, '0, 4'b0100, 7'd5, wayData(2, 34'h2_DEADBEEF), '0, "basic_wr");
      idle(1);
      readAt(7'd5, "basic_rd");
      idle(1);
      checkVal("basic_way2", DW'(data_out[2*W +: W]), DW'(34'h2_DEADBEEF));
      checkVal("basic_way0", DW'(data_out[0 +: W]), DW'(IV));

      $display("[TB] same-cycle bypass");
      applyStimulus(0, 0, 1, 7'd9, 4'b1111, 7'd9, {NW{34'h1_11111111}}, '0, "byp_all");
      idle(1);
      checkVal("byp_all_dout", data_out, {NW{34'h1_11111111}});
      applyStimulus(0, 0, 1, 7'd9, 4'b0100, 7'd9, {NW{34'h0_22223333}}, '0, "byp_w2");
      idle(1);
      checkVal("byp_w2_way2", DW'(data_out[2*W +: W]), DW'(34'h0_22223333));
      checkVal("byp_w2_way1", DW'(data_out[1*W +: W]), DW'(34'h1_11111111));

      $display("[TB] late-write forwarding");
      readAt(7'd3, "late_rd");
      applyStimulus(0, 0, 0, '0, 4'b0001, 7'd3, wayData(0, 34'h3_0000ABCD), '0, "late_wr");
      checkVal("late_way0", DW'(data_out[0 +: W]), DW'(34'h3_0000ABCD));
      checkVal("late_rd_val", DW'(rd_val), DW'(1'b1));

      $display("[TB] parity inject");
      applyStimulus(0, 0, 0, '0, 4'b0110, 7'd7, {NW{34'h0_0F0F00F1}}, 4'b0100, "par_wr");
      readAt(7'd7, "par_rd");
      idle(1);
      checkVal("par_err_inj", DW'(par_err), DW'(4'b0100));
      checkVal("par_data_intact", DW'(data_out[2*W +: W]), DW'(34'h0_0F0F00F1));
      applyStimulus(0, 0, 0, '0, 4'b0110, 7'd7, {NW{34'h0_0F0F00F1}}, '0, "par_fix");
      readAt(7'd7, "par_rd2");
      idle(1);
      checkVal("par_err_clear", DW'(par_err), DW'(4'b0000));

      $display("[TB] random traffic");
      for (int i = 0; i < 600; i++) randStep(15, "rand");
      idle(2);

      $display("[TB] init_req then reset mid-clear");
      applyStimulus(0, 1, 1, 7'd5, '0, '0, '0, '0, "init_req");
      checkVal("init_req_busy", DW'(init_busy), DW'(1'b1));
      idle(1);
      checkVal("rd_before_init", DW'(rd_val), DW'(1'b1));
      for (int i = 0; i < 38; i++) randStep(DEPTH - 1, "clr40");
      applyStimulus(1, 0, 0, '0, '0, '0, '0, '0, "rst_mid");
      countBusy(init_busy ? 1 : 0, cnt);
      checkVal("busy_len_restart", DW'(cnt), DW'(DEPTH));
      for (int a = 0; a < DEPTH; a++) readAt(AW'(a), "reclr_rd");
      idle(2);

      $display("[TB] reset squashes a pending read");
      for (int i = 0; i < 40; i++) randStep(15, "rand2");
      readAt(7'd9, "sq_rd");
      applyStimulus(1, 0, 0, '0, '0, '0, '0, '0, "sq_rst");
      checkVal("rst_squash", DW'(rd_val), DW'(1'b0));
      countBusy(init_busy ? 1 : 0, cnt);
      checkVal("busy_len_final", DW'(cnt), DW'(DEPTH));
      readAt(7'd9, "final_rd");
      idle(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
